// File: rtl/ifu_fetch_queue.sv
// Multi-issue IFU fetch queue: masked, packed enqueue; per-slot valid/ready dequeue; 1-cycle latency (0 with FETCHQ_BYPASS_EN).
// Backpressure: enq_ready drops when fewer than FETCH_NUM entries are free; only the leading run of deq_valid&deq_ready is consumed.
module ifu_fetch_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int ISSUE_NUM  = 4,
    parameter int FETCH_NUM  = 4,
    parameter int DEPTH      = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            clr,
    input  logic                            enq_valid,
    output logic                            enq_ready,
    input  logic [ADDR_WIDTH-1:0]           enq_pc,
    input  logic [FETCH_NUM*32-1:0]         enq_inst,
    input  logic [FETCH_NUM-1:0]            enq_mask,
    output logic [ISSUE_NUM-1:0]            deq_valid,
    input  logic [ISSUE_NUM-1:0]            deq_ready,
    output logic [ISSUE_NUM*32-1:0]         deq_inst,
    output logic [ISSUE_NUM*ADDR_WIDTH-1:0] deq_pc,
    output logic [$clog2(DEPTH+1)-1:0]      count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [31:0]           mem_inst_q [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_pc_q   [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] n_enq, n_enq_eff, n_deq;
    logic [CNT_W-1:0] slot_off [FETCH_NUM];
    logic [FETCH_NUM-1:0] slot_wr;
    logic             enq_fire;
    logic             deq_run;
`ifdef FETCHQ_BYPASS_EN
    logic             byp;
    assign byp = enq_fire && (count_q == '0);
`endif

    assign enq_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(FETCH_NUM);
    assign enq_fire  = enq_valid && enq_ready && !clr;
    assign n_enq_eff = enq_fire ? n_enq : '0;
    assign count     = count_q;

    // slot_off[i] is the packed position of slot i: number of mask bits below it
    always_comb begin
        n_enq = '0;
        for (int i = 0; i < FETCH_NUM; i++) begin
            slot_off[i] = n_enq;
            if (enq_mask[i]) n_enq = n_enq + CNT_W'(1);
        end
    end

    always_comb begin
        deq_valid = '0;
        deq_inst  = '0;
        deq_pc    = '0;
        for (int j = 0; j < ISSUE_NUM; j++) begin
            if (!clr && (count_q > CNT_W'(j))) begin
                deq_valid[j]                       = 1'b1;
                deq_inst[32*j +: 32]               = mem_inst_q[rd_ptr_q + PTR_W'(j)];
                deq_pc[ADDR_WIDTH*j +: ADDR_WIDTH] = mem_pc_q[rd_ptr_q + PTR_W'(j)];
            end
        end
`ifdef FETCHQ_BYPASS_EN
        if (byp) begin
            for (int j = 0; j < ISSUE_NUM; j++) begin
                for (int i = 0; i < FETCH_NUM; i++) begin
                    if (enq_mask[i] && (slot_off[i] == CNT_W'(j))) begin
                        deq_valid[j]                       = 1'b1;
                        deq_inst[32*j +: 32]               = enq_inst[32*i +: 32];
                        deq_pc[ADDR_WIDTH*j +: ADDR_WIDTH] = enq_pc + ADDR_WIDTH'(4*i);
                    end
                end
            end
        end
`endif
    end

    always_comb begin
        n_deq   = '0;
        deq_run = 1'b1;
        for (int j = 0; j < ISSUE_NUM; j++) begin
            deq_run = deq_run & deq_valid[j] & deq_ready[j];
            if (deq_run) n_deq = n_deq + CNT_W'(1);
        end
    end

    // Bypassed slots consumed in the same cycle never touch storage
    always_comb begin
        for (int i = 0; i < FETCH_NUM; i++) begin
            slot_wr[i] = enq_fire && enq_mask[i];
`ifdef FETCHQ_BYPASS_EN
            if (byp && (slot_off[i] < n_deq)) slot_wr[i] = 1'b0;
`endif
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(n_deq);
        wr_ptr_d = wr_ptr_q + PTR_W'(n_enq_eff);
        count_d  = count_q + n_enq_eff - n_deq;
        if (clr) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < FETCH_NUM; i++) begin
            if (slot_wr[i]) begin
                mem_inst_q[wr_ptr_q + PTR_W'(slot_off[i])] <= enq_inst[32*i +: 32];
                mem_pc_q[wr_ptr_q + PTR_W'(slot_off[i])]   <= enq_pc + ADDR_WIDTH'(4*i);
            end
        end
    end

    assert property (@(posedge clock) disable iff (reset) count_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue with a scoreboard of expected {inst, pc} entries.
module tb_ifu_fetch_queue;
    localparam int AW = 32;
    localparam int IN = 4;
    localparam int FN = 4;
    localparam int D  = 16;
    localparam int CW = 5;

    logic              clock = 1'b0;
    logic              reset;
    logic              clr;
    logic              enq_valid;
    logic              enq_ready;
    logic [AW-1:0]     enq_pc;
    logic [FN*32-1:0]  enq_inst;
    logic [FN-1:0]     enq_mask;
    logic [IN-1:0]     deq_valid;
    logic [IN-1:0]     deq_ready;
    logic [IN*32-1:0]  deq_inst;
    logic [IN*AW-1:0]  deq_pc;
    logic [CW-1:0]     count;

    int vectors     = 0;
    int miscompares = 0;
    logic [63:0] sb[$];
    logic        last_fire;
    logic [AW-1:0] run_pc;

    ifu_fetch_queue #(.ADDR_WIDTH(AW), .ISSUE_NUM(IN), .FETCH_NUM(FN), .DEPTH(D)) dut (
        .clock(clock), .reset(reset), .clr(clr),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc),
        .enq_inst(enq_inst), .enq_mask(enq_mask),
        .deq_valid(deq_valid), .deq_ready(deq_ready),
        .deq_inst(deq_inst), .deq_pc(deq_pc), .count(count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [IN-1:0] therm(input int n);
        logic [IN-1:0] v;
        v = '0;
        for (int j = 0; j < IN; j++) if (j < n) v[j] = 1'b1;
        return v;
    endfunction

    task automatic drive(input logic v, input logic [AW-1:0] pc, input logic [FN-1:0] m,
                         input logic [IN-1:0] r, input logic c);
        enq_valid = v;
        enq_pc    = pc;
        enq_mask  = m;
        deq_ready = r;
        clr       = c;
        for (int i = 0; i < FN; i++) enq_inst[32*i +: 32] = $urandom;
    endtask

    task automatic push_beat();
        for (int i = 0; i < FN; i++)
            if (enq_mask[i]) sb.push_back({enq_inst[32*i +: 32], enq_pc + AW'(4*i)});
    endtask

    // Called at posedge+1 with inputs set; checks at the negedge, then advances one cycle.
    task automatic tick();
        int sz;
        int nd;
        logic fire;
        logic pushed;
        logic [IN-1:0] ev;
        logic run;
        #4;
        sz     = sb.size();
        fire   = enq_valid && ((D - sz) >= FN) && !clr;
        pushed = 1'b0;
        chk("count", 64'(count), 64'(sz));
        chk("enq_ready", 64'(enq_ready), 64'((D - sz) >= FN));
`ifdef FETCHQ_BYPASS_EN
        if (fire && sz == 0) begin
            push_beat();
            pushed = 1'b1;
        end
`endif
        ev = clr ? '0 : therm(sb.size());
        chk("deq_valid", 64'(deq_valid), 64'(ev));
        nd  = 0;
        run = 1'b1;
        for (int j = 0; j < IN; j++) begin
            run = run & ev[j] & deq_ready[j];
            if (run) nd++;
        end
        for (int k = 0; k < nd; k++) begin
            chk("deq_pc", 64'(deq_pc[k*AW +: AW]), 64'(sb[0][AW-1:0]));
            chk("deq_inst", 64'(deq_inst[k*32 +: 32]), 64'(sb[0][63:32]));
            void'(sb.pop_front());
        end
        if (fire && !pushed) push_beat();
        if (clr) sb.delete();
        last_fire = fire;
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        drive(1'b0, '0, '0, 4'b1111, 1'b0);
        for (int n = 0; n < 5; n++) tick();
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, '0, '0, '0, 1'b0);
        #3;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_deq_valid", 64'(deq_valid), 64'd0);
        chk("rst_enq_ready", 64'(enq_ready), 64'd1);
        chk("rst_deq_pc", 64'(deq_pc[63:0]), 64'd0);
        chk("rst_deq_inst", 64'(deq_inst[63:0]), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Build count = 6, then reset asynchronously between edges
        drive(1'b1, 32'h0000_1000, 4'b1111, 4'b0000, 1'b0); tick();
        drive(1'b1, 32'h0000_1010, 4'b0011, 4'b0000, 1'b0); tick();
        drive(1'b0, '0, '0, '0, 1'b0);
        chk("pre_rst_count", 64'(count), 64'd6);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_deq_valid", 64'(deq_valid), 64'd0);
        chk("arst_enq_ready", 64'(enq_ready), 64'd1);
        sb.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Full-line enqueue, visible next cycle
        drive(1'b1, 32'h8000_0000, 4'b1111, 4'b0000, 1'b0); tick();
        chk("line_valid", 64'(deq_valid), 64'hF);
        chk("line_pc0", 64'(deq_pc[0*AW +: AW]), 64'h8000_0000);
        chk("line_pc1", 64'(deq_pc[1*AW +: AW]), 64'h8000_0004);
        chk("line_pc2", 64'(deq_pc[2*AW +: AW]), 64'h8000_0008);
        chk("line_pc3", 64'(deq_pc[3*AW +: AW]), 64'h8000_000C);
        drive(1'b0, '0, '0, 4'b1111, 1'b0); tick();

        // Partial mask with a hole at slot 0
        drive(1'b1, 32'h8000_0010, 4'b0110, 4'b0000, 1'b0); tick();
        chk("part_count", 64'(count), 64'd2);
        chk("part_valid", 64'(deq_valid), 64'h3);
        chk("part_pc0", 64'(deq_pc[0*AW +: AW]), 64'h8000_0014);
        chk("part_pc1", 64'(deq_pc[1*AW +: AW]), 64'h8000_0018);
        drain();

        // Fill to full; fifth beat must be ignored
        run_pc = 32'h8000_1000;
        for (int b = 0; b < 5; b++) begin
            drive(1'b1, run_pc, 4'b1111, 4'b0000, 1'b0); tick();
            if (last_fire) run_pc = run_pc + 32'd16;
        end
        chk("full_count", 64'(count), 64'd16);
        chk("full_enq_ready", 64'(enq_ready), 64'd0);

        // Concurrent dequeue and enqueue across the pointer wrap
        for (int b = 0; b < 6; b++) begin
            drive(1'b1, run_pc, 4'b1111, 4'b1111, 1'b0); tick();
            if (last_fire) run_pc = run_pc + 32'd16;
        end
        drain();
        chk("wrap_drained", 64'(count), 64'd0);

        // Non-prefix ready consumes only the leading run
        drive(1'b1, 32'h8000_2000, 4'b1111, 4'b0000, 1'b0); tick();
        drive(1'b0, '0, '0, 4'b1011, 1'b0); tick();
        chk("nonprefix_count", 64'(count), 64'd2);
        chk("nonprefix_pc0", 64'(deq_pc[0*AW +: AW]), 64'h8000_2008);
        drain();

        // Flush collides with enqueue and dequeue
        drive(1'b1, 32'h8000_3000, 4'b1111, 4'b0000, 1'b0); tick();
        drive(1'b1, 32'h8000_3010, 4'b1111, 4'b0000, 1'b0); tick();
        drive(1'b1, 32'h8000_3020, 4'b1111, 4'b1111, 1'b1); tick();
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(deq_valid), 64'd0);
        drive(1'b1, 32'h9000_0000, 4'b1111, 4'b0000, 1'b0); tick();
        chk("post_flush_pc0", 64'(deq_pc[0*AW +: AW]), 64'h9000_0000);
        drain();

        // Enqueue into an empty queue with a partial consumer
        drive(1'b1, 32'hA000_0000, 4'b1111, 4'b0011, 1'b0);
        #1;
`ifdef FETCHQ_BYPASS_EN
        chk("byp_same_cycle_valid", 64'(deq_valid), 64'hF);
`else
        chk("nobyp_same_cycle_valid", 64'(deq_valid), 64'h0);
`endif
        #(-1 + 1);
        tick();
`ifdef FETCHQ_BYPASS_EN
        chk("byp_next_count", 64'(count), 64'd2);
`else
        chk("nobyp_next_count", 64'(count), 64'd4);
`endif
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
